// File: rtl/t07_arb_pkg.sv
// t07_arb_pkg: shared op encoding and arbiter state type for the MMIO arbiter
package t07_arb_pkg;
  typedef enum logic [1:0] {
    RWI_IDLE  = 2'b00,
    RWI_WRITE = 2'b01,
    RWI_READ  = 2'b10,
    RWI_FETCH = 2'b11
  } rwi_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
  function automatic logic is_read(input rwi_t op);
    return op == RWI_READ || op == RWI_FETCH;
  endfunction
endpackage

// File: rtl/t07_busy_edge_detect.sv
// t07_busy_edge_detect: registers mem_busy and flags its falling edge (transaction completion)
module t07_busy_edge_detect (
  input  logic clk,
  input  logic nrst,
  input  logic busy_i,
  output logic busy_fall_o
);
  logic prev_busy_q;
  logic prev_busy_d;
  assign prev_busy_d = busy_i;
  assign busy_fall_o = prev_busy_q & ~busy_i;
  // previous-cycle busy, sampled every cycle regardless of arbiter state
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) prev_busy_q <= 1'b0;
    else prev_busy_q <= prev_busy_d;
endmodule

// File: rtl/t07_mmio_arbiter.sv
// t07_mmio_arbiter: round-robin share of one MMIO port between CPU (0) and DMA (1); T07_ARB_TIMEOUT_EN adds a watchdog
module t07_mmio_arbiter
  import t07_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [1:0]        req_i,
  input  logic [1:0]        rwi0_i,
  input  logic [1:0]        rwi1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        mem_rwi_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_busy_i
);
  arb_state_t        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d, done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  rwi_t              rwi_q, rwi_d;
  logic              last_q, last_d;
  logic              busy_fall, v0, v1, win;

  t07_busy_edge_detect u_edge (
    .clk        (clk),
    .nrst       (nrst),
    .busy_i     (mem_busy_i),
    .busy_fall_o(busy_fall)
  );

  assign v0  = req_i[0] & (rwi0_i != RWI_IDLE);
  assign v1  = req_i[1] & (rwi1_i != RWI_IDLE);
  assign win = (v0 & v1) ? ~last_q : v1;

`ifdef T07_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  assign err_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign err_o = 1'b0;
`endif

  // next-state: grant in IDLE, wait for busy to rise in ISSUE, complete on busy fall in WAIT
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    rdata_d = rdata_q;
    rwi_d   = rwi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
`ifdef T07_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef T07_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (!mem_busy_i && (v0 || v1)) begin
          state_d = ISSUE;
          gnt_d   = win ? 2'b10 : 2'b01;
          last_d  = win;
          rwi_d   = rwi_t'(win ? rwi1_i : rwi0_i);
          addr_d  = win ? addr1_i : addr0_i;
          wdata_d = win ? wdata1_i : wdata0_i;
        end
      end
      ISSUE: state_d = mem_busy_i ? WAIT : ISSUE;
      WAIT: if (busy_fall) begin
        state_d = IDLE;
        done_d  = gnt_q;
        gnt_d   = 2'b00;
        rwi_d   = RWI_IDLE;
        rdata_d = is_read(rwi_q) ? mem_rdata_i : rdata_q;
      end
      default: state_d = IDLE;
    endcase
`ifdef T07_ARB_TIMEOUT_EN
    if (state_q != IDLE) begin
      if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        done_d  = gnt_q;
        err_d   = 1'b1;
        gnt_d   = 2'b00;
        rwi_d   = RWI_IDLE;
        rdata_d = '0;
      end else cnt_d = cnt_q + CW'(1);
    end
`endif
  end

  // all arbiter state and registered outputs; last grant starts at 1 so master 0 wins the first tie
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      rdata_q <= '0;
      rwi_q   <= RWI_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b1;
`ifdef T07_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      rwi_q   <= rwi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
`ifdef T07_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign mem_rwi_o   = rwi_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_t07_mmio_arbiter.sv
// tb_t07_mmio_arbiter: directed table-driven bench for the MMIO arbiter (TIMEOUT_CYCLES=16)
module tb_t07_mmio_arbiter;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [1:0]  req = 2'b00, rwi0 = 2'b00, rwi1 = 2'b00;
  logic [31:0] a0 = '0, a1 = '0, w0 = '0, w1 = '0, mem_rdata = '0;
  logic        mem_busy = 1'b0;
  logic [1:0]  gnt_o, done_o, mem_rwi_o;
  logic        err_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  int total = 0, bad = 0;

  typedef struct {
    logic [1:0]  req, rwi0, rwi1;
    logic [31:0] a0, a1, w0, w1;
    int          busy_n;
    logic [31:0] rd;
    logic [1:0]  gnt, rwi;
    logic [31:0] addr, wdata, rdata;
  } vec_t;
  vec_t v[6];
  vec_t r;

  t07_mmio_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .nrst(nrst), .req_i(req), .rwi0_i(rwi0), .rwi1_i(rwi1),
    .addr0_i(a0), .addr1_i(a1), .wdata0_i(w0), .wdata1_i(w1),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .mem_rwi_o(mem_rwi_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata), .mem_busy_i(mem_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"}, 64'(gnt_o), 0);
    chk({tag, "_done"}, 64'(done_o), 0);
    chk({tag, "_err"}, 64'(err_o), 0);
    chk({tag, "_rdata"}, 64'(rdata_o), 0);
    chk({tag, "_rwi"}, 64'(mem_rwi_o), 0);
    chk({tag, "_addr"}, 64'(mem_addr_o), 0);
    chk({tag, "_wdata"}, 64'(mem_wdata_o), 0);
  endtask

  task automatic finish_txn(input int n, input logic [31:0] rd, input logic [1:0] owner,
                            input logic [31:0] exp_rdata);
    int k;
    mem_busy = 1'b1;
    repeat (n) @(negedge clk);
    chk("gnt_hold", 64'(gnt_o), 64'(owner));
    chk("done_early", 64'(done_o), 0);
    mem_busy = 1'b0;
    mem_rdata = rd;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done_o == 2'b00 && k < 5);
    chk("done_lat", 64'(k), 1);
    chk("done", 64'(done_o), 64'(owner));
    chk("rdata", 64'(rdata_o), 64'(exp_rdata));
    chk("gnt_clr", 64'(gnt_o), 0);
    chk("rwi_clr", 64'(mem_rwi_o), 0);
    req = 2'b00;
    rwi0 = 2'b00;
    rwi1 = 2'b00;
    @(negedge clk);
    chk("done_pulse", 64'(done_o), 0);
  endtask

  task automatic run_txn(input vec_t t);
    @(negedge clk);
    req = t.req; rwi0 = t.rwi0; rwi1 = t.rwi1;
    a0 = t.a0; a1 = t.a1; w0 = t.w0; w1 = t.w1;
    @(negedge clk);
    chk("gnt", 64'(gnt_o), 64'(t.gnt));
    chk("mem_rwi", 64'(mem_rwi_o), 64'(t.rwi));
    chk("mem_addr", 64'(mem_addr_o), 64'(t.addr));
    chk("mem_wdata", 64'(mem_wdata_o), 64'(t.wdata));
    finish_txn(t.busy_n, t.rd, t.gnt, t.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v[0] = '{2'b01, 2'b10, 2'b00, 32'h3300_0010, 32'h0, 32'h0, 32'h0, 3, 32'hDEAD_BEEF,
             2'b01, 2'b10, 32'h3300_0010, 32'h0, 32'hDEAD_BEEF};
    v[1] = '{2'b10, 2'b00, 2'b01, 32'h0, 32'h3300_0100, 32'h0, 32'hA5A5_0001, 2, 32'h1234_5678,
             2'b10, 2'b01, 32'h3300_0100, 32'hA5A5_0001, 32'hDEAD_BEEF};
    v[2] = '{2'b11, 2'b10, 2'b11, 32'h100, 32'h200, 32'h11, 32'h22, 1, 32'h1111,
             2'b01, 2'b10, 32'h100, 32'h11, 32'h1111};
    v[3] = '{2'b11, 2'b10, 2'b11, 32'h104, 32'h204, 32'h11, 32'h22, 1, 32'h2222,
             2'b10, 2'b11, 32'h204, 32'h22, 32'h2222};
    v[4] = '{2'b11, 2'b01, 2'b11, 32'h108, 32'h208, 32'h33, 32'h22, 2, 32'h3333,
             2'b01, 2'b01, 32'h108, 32'h33, 32'h2222};
    v[5] = '{2'b11, 2'b10, 2'b10, 32'h10C, 32'h20C, 32'h33, 32'h44, 1, 32'h4444,
             2'b10, 2'b10, 32'h20C, 32'h44, 32'h4444};
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_req", 64'(gnt_o), 0);
    for (int i = 0; i < 6; i++) run_txn(v[i]);
    req = 2'b01; rwi0 = 2'b00;
    repeat (3) @(negedge clk);
    chk("rwi00_ignored", 64'(gnt_o), 0);
    req = 2'b00;
    mem_busy = 1'b1;
    req = 2'b01; rwi0 = 2'b10; a0 = 32'h3300_0040;
    repeat (3) @(negedge clk);
    chk("busy_idle_no_gnt", 64'(gnt_o), 0);
    mem_busy = 1'b0;
    @(negedge clk);
    chk("busy_idle_gnt", 64'(gnt_o), 2'b01);
    chk("busy_idle_addr", 64'(mem_addr_o), 32'h3300_0040);
    finish_txn(2, 32'h5555_AAAA, 2'b01, 32'h5555_AAAA);
    @(negedge clk);
    req = 2'b10; rwi1 = 2'b10; a1 = 32'h3300_0200;
    @(negedge clk);
    chk("rstw_gnt", 64'(gnt_o), 2'b10);
    mem_busy = 1'b1;
    repeat (2) @(negedge clk);
    #2 nrst = 1'b0;
    #1 chk_reset_vals("rstw");
    mem_busy = 1'b0;
    req = 2'b00; rwi1 = 2'b00;
    @(negedge clk);
    chk("rstw_no_done", 64'(done_o), 0);
    nrst = 1'b1;
    r = '{2'b01, 2'b10, 2'b00, 32'h3300_0020, 32'h0, 32'h0, 32'h0, 2, 32'hCAFE_F00D,
          2'b01, 2'b10, 32'h3300_0020, 32'h0, 32'hCAFE_F00D};
    run_txn(r);
    @(negedge clk);
    req = 2'b01; rwi0 = 2'b10; a0 = 32'h3300_0030;
    @(negedge clk);
    chk("to_gnt", 64'(gnt_o), 2'b01);
    mem_busy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 15) chk("to_done_early", 64'(done_o), 0);
    end
`ifdef T07_ARB_TIMEOUT_EN
    chk("to_done", 64'(done_o), 2'b01);
    chk("to_err", 64'(err_o), 1);
    chk("to_rdata", 64'(rdata_o), 0);
    chk("to_gnt_clr", 64'(gnt_o), 0);
    req = 2'b00; rwi0 = 2'b00;
    @(negedge clk);
    chk("to_err_pulse", 64'(err_o), 0);
    chk("to_done_pulse", 64'(done_o), 0);
    mem_busy = 1'b0;
    repeat (2) @(negedge clk);
`else
    chk("to_hold_gnt", 64'(gnt_o), 2'b01);
    chk("to_no_done", 64'(done_o), 0);
    chk("to_no_err", 64'(err_o), 0);
    repeat (20) @(negedge clk);
    chk("to_still_gnt", 64'(gnt_o), 2'b01);
    finish_txn(1, 32'h0BAD_F00D, 2'b01, 32'h0BAD_F00D);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
